// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/response handshake between fetch and imem.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and IF stage with stall/flush handling and multi-cycle imem latency.
module pc_fetch #(
  parameter logic [31:2] RESET_PC = 30'h00000C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] NPC,
  input  logic        stallSignal,
  input  logic        flushSignal,
  pc_fetch_if.master  imem,
  output logic [31:2] PC,
  output logic [31:0] if_id_instr,
  output logic [31:2] if_id_pc,
  output logic        if_id_valid,
  output logic        fetchBusy
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t state, nextState;
  logic [31:2] pendPc;
  logic [31:0] holdInstr;
  logic rdy, loadPc, usePend, loadPend, loadHold, loadIfId, clearValid;
  assign rdy = imem.imem_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= nextState;
  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:   nextState = flushSignal ? (rdy ? FETCH : DISCARD) : (rdy && stallSignal ? HOLD : FETCH);
      HOLD:    nextState = (flushSignal || !stallSignal) ? FETCH : HOLD;
      DISCARD: nextState = rdy ? FETCH : DISCARD;
      default: nextState = FETCH;
    endcase
  end
  // flush outranks stall everywhere; DISCARD ignores stall entirely
  always_comb begin
    imem.imem_req  = state != HOLD;
    imem.imem_addr = PC;
    fetchBusy      = state == DISCARD || (state == FETCH && !rdy);
    loadPc         = (state == FETCH && rdy && (flushSignal || !stallSignal))
                   || (state == HOLD && (flushSignal || !stallSignal))
                   || (state == DISCARD && rdy);
    usePend        = state == DISCARD && !flushSignal;
    loadPend       = flushSignal && !rdy && state != HOLD;
    loadHold       = state == FETCH && rdy && !flushSignal && stallSignal;
    loadIfId       = !flushSignal && !stallSignal && ((state == FETCH && rdy) || state == HOLD);
    clearValid     = flushSignal || state == DISCARD || (state == FETCH && !rdy && !stallSignal);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      PC          <= RESET_PC;
      pendPc      <= '0;
      holdInstr   <= '0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      if (loadPc) PC <= usePend ? pendPc : NPC;
      if (loadPend) pendPc <= NPC;
      if (loadHold) holdInstr <= imem.imem_rdata;
      if (loadIfId) begin
        if_id_instr <= state == HOLD ? holdInstr : imem.imem_rdata;
        if_id_pc    <= PC;
      end
      if_id_valid <= loadIfId || (if_id_valid && !clearValid);
    end
endmodule
